// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : uart_pkg                                                   |
// | Description : Shared UART definitions. These are the FSM state encoding, |
// |               the serial line levels and the default bit period.         |
// |               The transmitter uses this package now, and the receiver    |
// |               will use it later.                                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_pkg;

    // Explicit 3-bit encoding. PARITY is always enumerated, and it is only
    // reachable when the parity build option is enabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd5,
        PARITY = 3'd6
    } uart_state_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_baud_tick                                             |
// | Description : Bit-period counter for the UART. It counts from 0 up to    |
// |               CLKS_PER_BIT-1 and then wraps. o_tick is high in the last  |
// |               cycle of each bit. A synchronous clear holds the count at  |
// |               zero.                                                      |
// | Ports       : clk    - system clock, rising edge                         |
// |               rst_n  - asynchronous active-low reset                     |
// |               i_clr  - synchronous clear (count forced to 0)             |
// |               o_cnt  - current count                                     |
// |               o_tick - count == CLKS_PER_BIT-1                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_uart_tx                                               |
// | Description : Drains the byte FIFO and sends each byte as an 8N1 UART    |
// |               frame on tx. The FIFO read data is registered, so the      |
// |               byte read in FETCH is captured in LOAD.                    |
// |               Build option FIFO_UART_TX_PARITY_EN inserts an even-parity |
// |               bit between the data bits and the stop bit.                |
// | Ports       : clk        - system clock, rising edge                     |
// |               rst_n      - asynchronous active-low reset                 |
// |               tx_en      - allows a new frame to start                   |
// |               fifo_empty - FIFO empty flag                               |
// |               fifo_dout  - FIFO read data (one cycle after fifo_re)      |
// |               fifo_re    - FIFO read enable, one cycle per byte          |
// |               tx         - serial line, idles high                       |
// |               busy       - high whenever the FSM is not in IDLE          |
// |               frame_done - pulse on the last cycle of the stop bit       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_re,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(DATA_W - 1);
    // frame_done is registered. It is armed one cycle before the final
    // stop-bit cycle, so that it is high in the final cycle itself.
    localparam logic [CNT_W-1:0] c_pre_last = CNT_W'(CLKS_PER_BIT - 2);

    uart_state_t       r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_tx;
    logic              r_frame_done;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic [CNT_W-1:0]  w_cnt;
    logic              w_tick;
    logic              w_clr;
    logic [DATA_W-1:0] w_shift_nxt;

    // The counter is held at zero until the frame starts. This means START
    // begins counting from 0. Later bit boundaries wrap on their own.
    assign w_clr = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .o_cnt  (w_cnt),
        .o_tick (w_tick)
    );

    assign w_shift_nxt = r_shift >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_tx         <= UART_IDLE;
            r_frame_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= UART_IDLE;
                    if (tx_en && !fifo_empty) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_shift   <= fifo_dout;
                    r_bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    r_parity  <= ^fifo_dout;
`endif
                    r_tx      <= UART_START;
                    r_state   <= START;
                end
                START: begin
                    if (w_tick) begin
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift   <= w_shift_nxt;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_bit) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= UART_IDLE;
                            r_state <= STOP;
`endif
                        end else begin
                            // tx always follows the LSB of the shift register.
                            r_tx <= w_shift_nxt[0];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_tx    <= UART_IDLE;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    r_tx <= UART_IDLE;
                    if (w_cnt == c_pre_last) begin
                        r_frame_done <= 1'b1;
                    end
                    if (w_tick) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= UART_IDLE;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // fifo_re and busy are decoded directly from the state register.
    assign fifo_re    = (r_state == FETCH);
    assign busy       = (r_state != IDLE);
    assign tx         = r_tx;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_uart_tx                                            |
// | Description : Directed self-checking bench for fifo_uart_tx. It uses     |
// |               CLKS_PER_BIT=4 and a registered-read FIFO model. Building  |
// |               with FIFO_UART_TX_PARITY_EN adds the parity bit to the     |
// |               expected frames and adds the parity vectors.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB  = DW + 3;
`else
    localparam int NB  = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_re;
    logic          tx;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_re    (fifo_re),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // FIFO model: registered read data, and 0 on cycles with no read.
    logic [DW-1:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int re_cnt = 0;
    int re_err = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_re) begin
            re_cnt <= re_cnt + 1;
            if (fifo_empty) re_err <= re_err + 1;
        end
        if (fifo_re && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end else begin
            fifo_dout <= '0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Steps negedge by negedge until fifo_re is seen or max cycles pass.
    // The return values are the number of cycles taken and whether tx left
    // idle while waiting.
    task automatic wait_re(input int max, output bit found, output int cycles, output bit tx_low);
        int i;
        i      = 0;
        found  = 1'b0;
        cycles = 0;
        tx_low = 1'b0;
        while (!found && i < max) begin
            @(negedge clk);
            i++;
            if (tx !== 1'b1) tx_low = 1'b1;
            if (fifo_re === 1'b1) begin
                found  = 1'b1;
                cycles = i;
            end
        end
    endtask

    // Entered at the negedge of the FETCH cycle (N+1). The first tx sample
    // is taken at N+3 and the last at the final stop cycle.
    task automatic frame_body(input logic [DW-1:0] b, input string tag);
        logic [NB-1:0] exp_bits;
        logic [3:0]    seen;
        int            fd_cnt;
        exp_bits          = '1;
        exp_bits[0]       = 1'b0;
        exp_bits[DW:1]    = b;
`ifdef FIFO_UART_TX_PARITY_EN
        exp_bits[DW+1]    = ^b;
`endif
        @(negedge clk);
        chk({tag, " load tx"}, 32'(tx), 32'd1);
        fd_cnt = 0;
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                seen[c] = tx;
                if (frame_done === 1'b1) fd_cnt++;
            end
            chk($sformatf("%s bit%0d", tag, k), 32'(seen), 32'({4{exp_bits[k]}}));
        end
        chk({tag, " frame_done last"}, 32'(frame_done), 32'd1);
        chk({tag, " frame_done count"}, 32'(fd_cnt), 32'd1);
        chk({tag, " busy last"}, 32'(busy), 32'd1);
    endtask

    task automatic send_frame(input logic [DW-1:0] b, input string tag);
        bit found;
        bit low;
        int cyc;
        wait_re(200, found, cyc, low);
        chk({tag, " re seen"}, 32'(found), 32'd1);
        if (found) frame_body(b, tag);
    endtask

    logic [DW-1:0] burst [0:2];

    initial begin
        bit found;
        bit low;
        int cyc;
        int re0;

        // Reset is held with a non-empty FIFO.
        rst_n = 1'b0;
        tx_en = 1'b1;
        push(8'h5A);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("reset tx/busy/re c%0d", i), 32'({tx, busy, fifo_re}), 32'b100);
        end
        re0   = re_cnt;
        rst_n = 1'b1;
        send_frame(8'h5A, "rst_rel");
        chk("rst_rel re pulses", 32'(re_cnt - re0), 32'd1);

        // Single byte.
        re0 = re_cnt;
        push(8'hA5);
        send_frame(8'hA5, "single");
        chk("single re pulses", 32'(re_cnt - re0), 32'd1);

        // Burst: the bytes are pushed at the final stop cycle, so every frame
        // has the same 3-cycle high gap (IDLE, FETCH, LOAD).
        burst[0] = 8'h00;
        burst[1] = 8'hFF;
        burst[2] = 8'h3C;
        re0 = re_cnt;
        for (int i = 0; i < 3; i++) push(burst[i]);
        for (int i = 0; i < 3; i++) begin
            wait_re(50, found, cyc, low);
            chk($sformatf("burst%0d re gap", i), 32'(cyc), 32'd2);
            chk($sformatf("burst%0d gap tx high", i), 32'(low), 32'd0);
            if (found) frame_body(burst[i], $sformatf("burst%0d", i));
        end
        @(negedge clk);
        chk("burst busy after", 32'(busy), 32'd0);
        chk("burst re pulses", 32'(re_cnt - re0), 32'd3);

        // Empty FIFO: no read, and the line stays idle.
        wait_re(100, found, cyc, low);
        chk("empty no re", 32'(found), 32'd0);
        chk("empty tx high", 32'(low), 32'd0);

        // tx_en low with data waiting: no read.
        tx_en = 1'b0;
        push(8'h81);
        wait_re(50, found, cyc, low);
        chk("tx_en=0 no re", 32'(found), 32'd0);
        tx_en = 1'b1;
        send_frame(8'h81, "en_resume");

        // tx_en dropped mid-frame: the current frame completes and the next
        // byte is not fetched.
        push(8'h42);
        push(8'h24);
        wait_re(50, found, cyc, low);
        chk("mid_en re seen", 32'(found), 32'd1);
        tx_en = 1'b0;
        if (found) frame_body(8'h42, "mid_en");
        wait_re(60, found, cyc, low);
        chk("mid_en no next re", 32'(found), 32'd0);
        tx_en = 1'b1;
        send_frame(8'h24, "mid_en_next");

        // Reset asserted during data bit 3 of 0x37 (bit 3 = 0).
        re0 = re_cnt;
        push(8'h37);
        push(8'hC3);
        wait_re(50, found, cyc, low);
        chk("mid_rst re seen", 32'(found), 32'd1);
        repeat (19) @(negedge clk);      // negedge of N+20, inside bit 3
        chk("mid_rst tx before", 32'(tx), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst tx forced", 32'(tx), 32'd1);
        chk("mid_rst busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hC3, "after_rst");
        chk("mid_rst re pulses", 32'(re_cnt - re0), 32'd2);

`ifdef FIFO_UART_TX_PARITY_EN
        push(8'h07);
        send_frame(8'h07, "parity07");
        push(8'h03);
        send_frame(8'h03, "parity03");
`endif

        chk("re while empty", 32'(re_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
